// File: rtl/apb_cmd_queue.sv
// apb_cmd_queue
//   Buffers producer write/read commands in a small FIFO. Each command is
//   replayed on the APB master's user-side inputs for a fixed slot of cycles.
//   For a read, the master's read data is captured into a response register
//   and presented on a valid/ready response port.
//
// Ports
//   apb_clk, apb_rst          clock, synchronous active-high reset
//   cmd_valid/cmd_ready       producer handshake; cmd_wr_rd/cmd_addr/cmd_wdata payload
//   rsp_valid/rsp_ready       read response handshake; rsp_rdata/rsp_addr payload
//   apb_addr/apb_wdata/apb_wr_rd  command currently presented to the master
//   apb_rdata                 read data returned by the master
//   cmd_count                 FIFO occupancy
//   busy                      FIFO non-empty or a command slot in progress
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no slot running; pops the head when a command waits and no
//          | response is pending
// ST_DRIVE | apb_* held; slot_cnt counts down, last cycle captures reads
module apb_cmd_queue #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int SLOT_CYCLES = 4
) (
  input  logic                       apb_clk,
  input  logic                       apb_rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_wr_rd,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [DATA_WIDTH-1:0]      cmd_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic [ADDR_WIDTH-1:0]      rsp_addr,
  output logic [ADDR_WIDTH-1:0]      apb_addr,
  output logic [DATA_WIDTH-1:0]      apb_wdata,
  output logic                       apb_wr_rd,
  input  logic [DATA_WIDTH-1:0]      apb_rdata,
  output logic [$clog2(DEPTH):0]     cmd_count,
  output logic                       busy
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int SLOT_W  = $clog2(SLOT_CYCLES);
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  localparam logic [SLOT_W-1:0] SLOT_INIT = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_DRIVE
  } state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_cnt;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [ENTRY_W-1:0]  fifo_mem [DEPTH];

  logic push, pop, capture;

  assign cmd_ready = (cmd_count != CNT_FULL);
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (cmd_count != '0) || (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A pending response blocks every pop, writes too, to keep ordering.
        if ((cmd_count != '0) && !rsp_valid) begin
          pop     = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (slot_cnt == '0) begin
          capture = ~apb_wr_rd;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge apb_clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_wr_rd, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge apb_clk) begin
    if (apb_rst) begin
      state_q   <= ST_IDLE;
      slot_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_count <= '0;
      apb_addr  <= '0;
      apb_wdata <= '0;
      apb_wr_rd <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_addr  <= '0;
    end else begin
      state_q <= state_d;

      if (pop) begin
        {apb_wr_rd, apb_addr, apb_wdata} <= fifo_mem[rd_ptr];
        slot_cnt <= SLOT_INIT;
        rd_ptr   <= rd_ptr + 1'b1;
      end else if ((state_q == ST_DRIVE) && (slot_cnt != '0)) begin
        slot_cnt <= slot_cnt - 1'b1;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;

      case ({push, pop})
        2'b10:   cmd_count <= cmd_count + 1'b1;
        2'b01:   cmd_count <= cmd_count - 1'b1;
        default: cmd_count <= cmd_count;
      endcase

      // Capture only happens with rsp_valid low, so it never races the clear.
      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= apb_rdata;
        rsp_addr  <= apb_addr;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_queue.sv
// Testbench for apb_cmd_queue: a queue-based reference model predicts every
// output each cycle; a simple slave memory stands in for the APB master.
module tb_apb_cmd_queue;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SLOT  = 4;

  logic                  apb_clk = 1'b0;
  logic                  apb_rst;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr_rd;
  logic [AW-1:0]         cmd_addr;
  logic [DW-1:0]         cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DW-1:0]         rsp_rdata;
  logic [AW-1:0]         rsp_addr;
  logic [AW-1:0]         apb_addr;
  logic [DW-1:0]         apb_wdata;
  logic                  apb_wr_rd;
  logic [DW-1:0]         apb_rdata;
  logic [$clog2(DEPTH):0] cmd_count;
  logic                  busy;

  apb_cmd_queue #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .SLOT_CYCLES(SLOT)
  ) dut (
    .apb_clk  (apb_clk),
    .apb_rst  (apb_rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr_rd(cmd_wr_rd),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_addr (rsp_addr),
    .apb_addr (apb_addr),
    .apb_wdata(apb_wdata),
    .apb_wr_rd(apb_wr_rd),
    .apb_rdata(apb_rdata),
    .cmd_count(cmd_count),
    .busy     (busy)
  );

  always #5 apb_clk = ~apb_clk;

  // Slave side: reads see the memory at the presented address, writes land
  // once they are presented (re-running the same write is harmless).
  logic [DW-1:0] slave_mem [1<<AW];
  assign apb_rdata = slave_mem[apb_addr];

  typedef struct {
    bit          wr;
    bit [AW-1:0] addr;
    bit [DW-1:0] data;
  } cmd_t;

  cmd_t          mq[$];
  cmd_t          m_apb;
  bit            m_active;
  int            m_left;
  bit            m_rv;
  bit [DW-1:0]   m_rdata;
  bit [AW-1:0]   m_raddr;
  bit [DW-1:0]   model_mem [1<<AW];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_apb    = '{wr: 1'b0, addr: '0, data: '0};
    m_active = 1'b0;
    m_left   = 0;
    m_rv     = 1'b0;
    m_rdata  = '0;
    m_raddr  = '0;
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model
  // by the upcoming edge, then let the clock edge happen.
  task automatic step(input bit rst, input bit vld, input bit wr,
                      input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input bit rready);
    bit push, old_rv;
    apb_rst   = rst;
    cmd_valid = vld;
    cmd_wr_rd = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    rsp_ready = rready;
    #1;
    check("cmd_ready", cmd_ready, (mq.size() < DEPTH));
    check("cmd_count", cmd_count, mq.size());
    check("busy",      busy,      (mq.size() != 0) || m_active);
    check("apb_addr",  apb_addr,  m_apb.addr);
    check("apb_wdata", apb_wdata, m_apb.data);
    check("apb_wr_rd", apb_wr_rd, m_apb.wr);
    check("rsp_valid", rsp_valid, m_rv);
    if (m_rv) begin
      check("rsp_rdata", rsp_rdata, m_rdata);
      check("rsp_addr",  rsp_addr,  m_raddr);
    end

    push   = vld && (mq.size() < DEPTH);
    old_rv = m_rv;
    if (rst) begin
      model_reset();
    end else begin
      if (m_rv && rready) m_rv = 1'b0;
      if (!m_active) begin
        if (mq.size() != 0 && !old_rv) begin
          m_apb    = mq.pop_front();
          m_active = 1'b1;
          m_left   = SLOT;
          if (m_apb.wr) model_mem[m_apb.addr] = m_apb.data;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_active = 1'b0;
          if (!m_apb.wr) begin
            m_rv    = 1'b1;
            m_rdata = model_mem[m_apb.addr];
            m_raddr = m_apb.addr;
          end
        end
      end
      if (push) mq.push_back('{wr: wr, addr: addr, data: data});
    end

    @(posedge apb_clk);
    @(negedge apb_clk);
    if (apb_wr_rd) slave_mem[apb_addr] = apb_wdata;
  endtask

  task automatic idle(input int n, input bit rready);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, rready);
  endtask

  // Present a command until the model says it was accepted (bounded).
  task automatic push_cmd(input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input bit rready);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) begin
      acc = (mq.size() < DEPTH);
      step(1'b0, 1'b1, wr, addr, data, rready);
    end
    if (!acc) check("push_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      slave_mem[i] = $urandom;
      model_mem[i] = slave_mem[i];
    end
    apb_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr_rd = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge apb_clk);

    // Write sweep
    for (int i = 0; i < 5; i++) push_cmd(1'b1, AW'(i), DW'(32'hA0 + i), 1'b1);
    idle(30, 1'b1);

    // Write then read of the same address
    push_cmd(1'b1, AW'(3), 32'h1234_5678, 1'b1);
    push_cmd(1'b0, AW'(3), '0, 1'b1);
    idle(15, 1'b1);
    check("wr_rd_data", model_mem[3], 32'h1234_5678);

    // Full FIFO: six back-to-back commands
    for (int i = 0; i < 6; i++) push_cmd(i[0], AW'(16 + i), $urandom, 1'b1);
    idle(40, 1'b1);

    // Response stall
    push_cmd(1'b0, AW'(1), '0, 1'b0);
    push_cmd(1'b0, AW'(2), '0, 1'b0);
    idle(20, 1'b0);
    idle(20, 1'b1);

    // Reset mid-DRIVE with commands queued
    for (int i = 0; i < 4; i++) push_cmd(1'b0, AW'(8 + i), '0, 1'b1);
    idle(1, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    idle(20, 1'b1);

    // Wrap-around with mixed commands
    for (int i = 0; i < 3 * DEPTH; i++)
      push_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom, 1'b1);
    idle(60, 1'b1);

    // Free-running random traffic with occasional resets and back-pressure
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 3) != 0));
    idle(40, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
